// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM states, line levels,
// parity selectors and the per-frame configuration bundle.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP1  = 3'd5,
        S_STOP2  = 3'd6
    } tx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    // Frame options captured with the data word. The parity bit itself is
    // stored rather than the parity type, so it is computed once at accept.
    typedef struct packed {
        logic par_en;
        logic par_bit;
        logic stop2;
        logic msb_first;
    } frame_cfg_t;

endpackage

// File: rtl/uart_parity_gen.sv
// Combinational parity generator, shared by the TX frame generator and the
// RX parity checker.
module uart_parity_gen
    import uart_tx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_par_typ,
    output logic              o_par_bit
);

    // Even parity is the plain XOR reduction; odd parity inverts it.
    always_comb begin
        o_par_bit = (^i_data) ^ (i_par_typ == PAR_ODD);
    end

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmit frame generator: accepts a parallel word over valid/ready,
// then emits start, data, optional parity and one or two stop bits on a
// registered line output, one bit per BIT_TICK. A one-deep pending register
// lets the next frame start directly after the last stop bit.
module uart_tx_frame_gen
    import uart_tx_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bit_tick,
    input  logic [DATA_W-1:0] i_p_data,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    input  logic              i_par_en,
    input  logic              i_par_typ,
    input  logic              i_stop_2,
    input  logic              i_msb_first,
    output logic              o_tx_out,
    output logic              o_busy,
    output logic              o_frame_done
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // Active frame state
    tx_state_e         r_state;
    logic              r_tx;
    logic              r_done;
    logic              r_live;
    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    frame_cfg_t        r_cfg;

    // One-deep pending word accepted during the final stop bit
    logic              r_pend_vld;
    logic [DATA_W-1:0] r_pend_data;
    frame_cfg_t        r_pend_cfg;

    logic              w_par_bit;
    frame_cfg_t        w_in_cfg;
    logic              w_final_stop;
    logic              w_ready;
    logic              w_accept;
    logic              w_frame_end;
    logic              w_next_bit;
    logic [DATA_W-1:0] w_shifted;

    uart_parity_gen #(
        .DATA_W (DATA_W)
    ) u_parity (
        .i_data    (i_p_data),
        .i_par_typ (i_par_typ),
        .o_par_bit (w_par_bit)
    );

    // Decode of handshake, final-stop position and the next data bit
    always_comb begin
        w_in_cfg.par_en    = i_par_en;
        w_in_cfg.par_bit   = w_par_bit;
        w_in_cfg.stop2     = i_stop_2;
        w_in_cfg.msb_first = i_msb_first;

        w_final_stop = ((r_state == S_STOP1) && !r_cfg.stop2) || (r_state == S_STOP2);
        // r_live holds ready low while in reset and for no longer
        w_ready      = r_live && ((r_state == S_IDLE) || (w_final_stop && !r_pend_vld));
        w_accept     = i_data_valid && w_ready;
        w_frame_end  = i_bit_tick && w_final_stop;

        w_next_bit   = r_cfg.msb_first ? r_shift[DATA_W-1] : r_shift[0];
        w_shifted    = r_cfg.msb_first ? (r_shift << 1) : (r_shift >> 1);
    end

    // Frame FSM: state, line output, bit counter, shifter and pending slot
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_tx        <= STOP_BIT;
            r_done      <= 1'b0;
            r_live      <= 1'b0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_cfg       <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_data <= '0;
            r_pend_cfg  <= '0;
        end else begin
            r_live <= 1'b1;
            r_done <= 1'b0;

            // A word accepted mid-frame waits in the pending slot unless the
            // same edge ends the frame, in which case it is launched directly.
            if (w_accept && (r_state != S_IDLE) && !w_frame_end) begin
                r_pend_vld  <= 1'b1;
                r_pend_data <= i_p_data;
                r_pend_cfg  <= w_in_cfg;
            end

            case (r_state)
                S_IDLE: begin
                    // A tick coincident with accept is deliberately ignored
                    if (w_accept) begin
                        r_shift <= i_p_data;
                        r_cfg   <= w_in_cfg;
                        r_state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (i_bit_tick) begin
                        r_tx    <= START_BIT;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (i_bit_tick) begin
                        r_tx    <= w_next_bit;
                        r_shift <= w_shifted;
                        r_cnt   <= '0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (i_bit_tick) begin
                        if (r_cnt == LAST_BIT) begin
                            if (r_cfg.par_en) begin
                                r_tx    <= r_cfg.par_bit;
                                r_state <= S_PARITY;
                            end else begin
                                r_tx    <= STOP_BIT;
                                r_state <= S_STOP1;
                            end
                        end else begin
                            r_tx    <= w_next_bit;
                            r_shift <= w_shifted;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (i_bit_tick) begin
                        r_tx    <= STOP_BIT;
                        r_state <= S_STOP1;
                    end
                end
                S_STOP1, S_STOP2: begin
                    if (i_bit_tick) begin
                        if (!w_final_stop) begin
                            r_tx    <= STOP_BIT;
                            r_state <= S_STOP2;
                        end else begin
                            r_done     <= 1'b1;
                            r_pend_vld <= 1'b0;
                            if (r_pend_vld || w_accept) begin
                                // Back-to-back: skip ARM and the idle bit
                                r_shift <= r_pend_vld ? r_pend_data : i_p_data;
                                r_cfg   <= r_pend_vld ? r_pend_cfg  : w_in_cfg;
                                r_tx    <= START_BIT;
                                r_state <= S_START;
                            end else begin
                                r_tx    <= STOP_BIT;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    r_tx    <= STOP_BIT;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are registered or decoded from registered state only
    always_comb begin
        o_data_ready = w_ready;
        o_tx_out     = r_tx;
        o_busy       = (r_state != S_IDLE);
        o_frame_done = r_done;
    end

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Directed bench for uart_tx_frame_gen (DATA_W = 8). Line values are sampled
// on the falling edge following each BIT_TICK rising edge.
module tb_uart_tx_frame_gen;

    logic       clk;
    logic       rst;
    logic       bit_tick;
    logic [7:0] p_data;
    logic       data_valid;
    logic       data_ready;
    logic       par_en;
    logic       par_typ;
    logic       stop_2;
    logic       msb_first;
    logic       tx_out;
    logic       busy;
    logic       frame_done;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    uart_tx_frame_gen #(.DATA_W(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_bit_tick   (bit_tick),
        .i_p_data     (p_data),
        .i_data_valid (data_valid),
        .o_data_ready (data_ready),
        .i_par_en     (par_en),
        .i_par_typ    (par_typ),
        .i_stop_2     (stop_2),
        .i_msb_first  (msb_first),
        .o_tx_out     (tx_out),
        .o_busy       (busy),
        .o_frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Two quiet cycles, then a one-cycle tick; returns at the sampling edge
    task automatic tick();
        repeat (2) @(negedge clk);
        bit_tick = 1'b1;
        @(negedge clk);
        bit_tick = 1'b0;
    endtask

    // Present a word, wait (bounded) for acceptance, then scramble all
    // inputs so any late sampling by the DUT corrupts the frame.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                        input logic s2, input logic mf, input string tag);
        bit ok;
        ok = 1'b0;
        p_data = d; par_en = pe; par_typ = pt; stop_2 = s2; msb_first = mf;
        data_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (data_ready) ok = 1'b1;
            @(negedge clk);
        end
        data_valid = 1'b0;
        p_data = ~d; par_en = ~pe; par_typ = ~pt; stop_2 = ~s2; msb_first = ~mf;
        chk({tag, " accepted"}, ok, 1'b1);
    endtask

    // Expect n line values (first value in exp[n-1]); optionally the
    // frame-end tick after them, returning to idle.
    task automatic run_bits(input logic [15:0] exp, input int n, input bit end_frame,
                            input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s tx b%0d", tag, i), tx_out, exp[n-1-i]);
            chk($sformatf("%s done b%0d", tag, i), frame_done, 1'b0);
            chk($sformatf("%s busy b%0d", tag, i), busy, 1'b1);
        end
        if (end_frame) begin
            tick();
            chk({tag, " end tx"}, tx_out, 1'b1);
            chk({tag, " end done"}, frame_done, 1'b1);
            chk({tag, " end busy"}, busy, 1'b0);
            @(negedge clk);
            chk({tag, " done one cycle"}, frame_done, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; bit_tick = 1'b0; data_valid = 1'b0; p_data = '0;
        par_en = 1'b0; par_typ = 1'b0; stop_2 = 1'b0; msb_first = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst ready", data_ready, 1'b0);
        chk("rst tx", tx_out, 1'b1);
        chk("rst busy", busy, 1'b0);
        chk("rst done", frame_done, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst ready", data_ready, 1'b1);

        // 0xA5 LSB first, even parity, 1 stop
        send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, "a5");
        chk("a5 armed tx", tx_out, 1'b1);
        chk("a5 armed busy", busy, 1'b1);
        run_bits(16'b01010010101, 11, 1'b1, "a5");

        // 0x01 odd parity -> parity bit 0
        send(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, "01odd");
        run_bits(16'b01000000001, 11, 1'b1, "01odd");

        // 0x01 even parity -> parity bit 1, with a valid pulse that is
        // dropped while busy (never accepted, so nothing further is sent)
        send(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, "01even");
        run_bits(16'b01000, 5, 1'b0, "01even hi");
        p_data = 8'hFF; data_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("dropped valid ready", data_ready, 1'b0);
        data_valid = 1'b0;
        run_bits(16'b000011, 6, 1'b1, "01even lo");
        tick();
        chk("no extra frame tx", tx_out, 1'b1);
        chk("no extra frame busy", busy, 1'b0);

        // 0x80 MSB first, no parity, 2 stop bits
        send(8'h80, 1'b0, 1'b0, 1'b1, 1'b1, "80msb");
        run_bits(16'b01000000011, 11, 1'b1, "80msb");

        // Back-to-back: 0xA5 then 0x3C (LSB, odd parity) offered in STOP1
        send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, "b2b1");
        run_bits(16'b01010010101, 11, 1'b0, "b2b1");
        send(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, "b2b2");
        chk("b2b pending ready", data_ready, 1'b0);
        tick();
        chk("b2b start tx", tx_out, 1'b0);
        chk("b2b first done", frame_done, 1'b1);
        chk("b2b busy", busy, 1'b1);
        run_bits(16'b0011110011, 10, 1'b1, "b2b2");

        // Reset in the middle of DATA
        send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, "rstmid");
        run_bits(16'b01010, 5, 1'b0, "rstmid");
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid tx", tx_out, 1'b1);
        chk("rstmid busy", busy, 1'b0);
        chk("rstmid done", frame_done, 1'b0);
        chk("rstmid ready", data_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid ready after", data_ready, 1'b1);
        send(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, "after rst");
        run_bits(16'b01000000001, 11, 1'b1, "after rst");

        // Accept and tick coincident in IDLE: tick ignored, then 0xC3 LSB,
        // no parity, 1 stop; inputs scrambled right after accept
        p_data = 8'hC3; par_en = 1'b0; par_typ = 1'b0; stop_2 = 1'b0; msb_first = 1'b0;
        data_valid = 1'b1; bit_tick = 1'b1;
        @(negedge clk);
        data_valid = 1'b0; bit_tick = 1'b0;
        p_data = 8'h3C; par_en = 1'b1; stop_2 = 1'b1; msb_first = 1'b1;
        chk("coinc tx", tx_out, 1'b1);
        chk("coinc busy", busy, 1'b1);
        run_bits(16'b0110000111, 10, 1'b1, "coinc");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
